// File: rtl/l2_req_scheduler.sv
// Shares the single L2 port between the I-cache miss path and the D-cache miss/writeback path.
// Fixed D-over-I priority; define L2_SCHED_STARVE_GUARD_EN to bound I-fetch latency via STARVE_LIMIT.
module l2_req_scheduler #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [15:0]  I_address,
    input  logic         I_read,
    output logic [127:0] I_rdata,
    output logic         I_resp,
    input  logic [15:0]  D_address,
    input  logic         D_read,
    input  logic         D_write,
    input  logic [127:0] D_wdata,
    output logic [127:0] D_rdata,
    output logic         D_resp,
    output logic [15:0]  L2_address,
    output logic         L2_read,
    output logic         L2_write,
    output logic [127:0] L2_wdata,
    input  logic [127:0] L2_rdata,
    input  logic         L2_resp,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_t;

    state_t         state_q;
    logic [15:0]    addr_q;
    logic [127:0]   wdata_q;
    logic           rd_q;
    logic           wr_q;
    logic           d_req;
    logic           force_i;
    logic           grant_d;
    logic           grant_i;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("STARVE_LIMIT must be in 1..15");
    end

    assign d_req = D_read | D_write;

`ifdef L2_SCHED_STARVE_GUARD_EN
    logic [3:0] starve_q;
    logic [3:0] starve_d;

    assign force_i = (starve_q == 4'(STARVE_LIMIT)) && I_read && d_req;

    // Only a D grant that leaves I waiting counts towards starvation.
    always_comb begin
        starve_d = starve_q;
        if (grant_d && I_read) begin
            if (starve_q != 4'(STARVE_LIMIT)) begin
                starve_d = starve_q + 4'd1;
            end
        end else if (grant_d || grant_i) begin
            starve_d = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q <= 4'd0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign force_i = 1'b0;
`endif

    assign grant_d = (state_q == IDLE) && d_req && !force_i;
    assign grant_i = (state_q == IDLE) && I_read && !grant_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        state_q <= SERVE_D;
                        addr_q  <= D_address;
                        wdata_q <= D_wdata;
                        wr_q    <= D_write;
                        rd_q    <= !D_write;
                    end else if (grant_i) begin
                        state_q <= SERVE_I;
                        addr_q  <= I_address;
                        rd_q    <= 1'b1;
                        wr_q    <= 1'b0;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (L2_resp) begin
                        state_q <= DONE;
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b0;
                    end
                end
                // Requester is still dropping its request; ignore everything for one cycle.
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign L2_address = addr_q;
    assign L2_wdata   = wdata_q;
    assign L2_read    = rd_q;
    assign L2_write   = wr_q;
    assign I_resp     = (state_q == SERVE_I) && L2_resp;
    assign D_resp     = (state_q == SERVE_D) && L2_resp;
    assign I_rdata    = L2_rdata;
    assign D_rdata    = L2_rdata;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_l2_req_scheduler.sv
// Bench for l2_req_scheduler: table of single transactions plus hand sequences for
// arbitration order, starvation behaviour, reset mid-service and back-to-back timing.
module tb_l2_req_scheduler;

    logic         clk = 1'b0;
    logic         reset;
    logic [15:0]  I_address;
    logic         I_read;
    logic [127:0] I_rdata;
    logic         I_resp;
    logic [15:0]  D_address;
    logic         D_read;
    logic         D_write;
    logic [127:0] D_wdata;
    logic [127:0] D_rdata;
    logic         D_resp;
    logic [15:0]  L2_address;
    logic         L2_read;
    logic         L2_write;
    logic [127:0] L2_wdata;
    logic [127:0] L2_rdata;
    logic         L2_resp;
    logic         busy;

    l2_req_scheduler #(.STARVE_LIMIT(2)) dut (
        .clk(clk), .reset(reset),
        .I_address(I_address), .I_read(I_read), .I_rdata(I_rdata), .I_resp(I_resp),
        .D_address(D_address), .D_read(D_read), .D_write(D_write), .D_wdata(D_wdata),
        .D_rdata(D_rdata), .D_resp(D_resp),
        .L2_address(L2_address), .L2_read(L2_read), .L2_write(L2_write),
        .L2_wdata(L2_wdata), .L2_rdata(L2_rdata), .L2_resp(L2_resp), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           is_d;
        bit           wr;
        logic [15:0]  addr;
        logic [127:0] wd;
    } exp_t;

    typedef struct {
        bit           i_rd;
        bit           d_rd;
        bit           d_wr;
        logic [15:0]  ia;
        logic [15:0]  da;
        logic [127:0] wd;
        int           wait_n;
        logic [127:0] rd;
        bit           chg;
        bit           exp_d;
        bit           exp_wr;
        logic [15:0]  exp_addr;
    } vec_t;

    exp_t q[$];
    vec_t vt[6];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   i_cnt = 0;
    int   d_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (I_resp) i_cnt <= i_cnt + 1;
        if (D_resp) d_cnt <= d_cnt + 1;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_strobe(output int n);
        n = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #2;
            if (L2_read || L2_write) begin
                n = k;
                break;
            end
        end
        if (n < 0) begin
            tests++;
            fails++;
            $display("FAIL strobe_timeout: got no L2 strobe expected one within 20 cycles");
        end
    endtask

    // Called at the cycle the strobe is first seen; checks the hold window, pulses L2_resp
    // after wait_n cycles, then checks the DONE cycle and drops the winner's request.
    task automatic serve(input int wait_n, input logic [127:0] rd, input bit chg, output int rc);
        exp_t e;
        rc = -1;
        if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_empty: got a strobe expected none");
            return;
        end
        e = q.pop_front();
        check("l2_address", L2_address, e.addr);
        check("l2_read", L2_read, !e.wr);
        check("l2_write", L2_write, e.wr);
        if (e.wr) check("l2_wdata", L2_wdata, e.wd);
        for (int k = 0; k < wait_n; k++) begin
            @(posedge clk); #1;
            if (chg && k == 0) D_address = 16'h5000;
            #1;
            check("hold_address", L2_address, e.addr);
            check("hold_strobe", {L2_read, L2_write}, {!e.wr, e.wr});
            if (e.wr) check("hold_wdata", L2_wdata, e.wd);
            check("early_resp", {I_resp, D_resp}, 2'b00);
        end
        L2_rdata = rd;
        L2_resp  = 1'b1;
        #1;
        rc = cyc;
        check("resp_address", L2_address, e.addr);
        if (e.is_d) begin
            check("d_resp", D_resp, 1'b1);
            check("i_resp_nonwinner", I_resp, 1'b0);
            check("d_rdata", D_rdata, rd);
        end else begin
            check("i_resp", I_resp, 1'b1);
            check("d_resp_nonwinner", D_resp, 1'b0);
            check("i_rdata", I_rdata, rd);
        end
        @(posedge clk); #1;
        L2_resp = 1'b0;
        if (e.is_d) begin
            D_read  = 1'b0;
            D_write = 1'b0;
        end else begin
            I_read = 1'b0;
        end
        #1;
        check("done_busy", busy, 1'b1);
        check("done_strobes", {L2_read, L2_write}, 2'b00);
        check("done_resp", {I_resp, D_resp}, 2'b00);
    endtask

    initial begin
        int   n;
        int   m_d;
        int   m_i;
        int   rc;
        int   i0;
        int   d0;
        exp_t e;
        bit   guard;
`ifdef L2_SCHED_STARVE_GUARD_EN
        guard = 1'b1;
`else
        guard = 1'b0;
`endif
        vt[0] = '{1'b1, 1'b0, 1'b0, 16'h1230, 16'h0000, 128'h0, 3, {8{16'h1111}}, 1'b0, 1'b0, 1'b0, 16'h1230};
        vt[1] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h4000, {16{8'hA5}}, 3, {8{16'h2222}}, 1'b1, 1'b1, 1'b1, 16'h4000};
        vt[2] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h2222, 128'h0, 0, {8{16'h3333}}, 1'b0, 1'b1, 1'b0, 16'h2222};
        vt[3] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h3030, {16{8'h0F}}, 1, {8{16'h4444}}, 1'b0, 1'b1, 1'b1, 16'h3030};
        vt[4] = '{1'b1, 1'b0, 1'b0, 16'hFFF0, 16'h0000, 128'h0, 0, {8{16'h5555}}, 1'b0, 1'b0, 1'b0, 16'hFFF0};
        vt[5] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, {128{1'b1}}, 2, {8{16'h6666}}, 1'b0, 1'b1, 1'b1, 16'h0000};

        reset = 1'b1; I_address = '0; I_read = 1'b0; D_address = '0; D_read = 1'b0;
        D_write = 1'b0; D_wdata = '0; L2_rdata = '0; L2_resp = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_strobes", {L2_read, L2_write}, 2'b00);
        check("rst_resp", {I_resp, D_resp}, 2'b00);
        check("rst_address", L2_address, 16'h0);
        check("rst_wdata", L2_wdata, 128'h0);

        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            I_read = vt[i].i_rd; I_address = vt[i].ia;
            D_read = vt[i].d_rd; D_write = vt[i].d_wr;
            D_address = vt[i].da; D_wdata = vt[i].wd;
            q.push_back('{vt[i].exp_d, vt[i].exp_wr, vt[i].exp_addr, vt[i].wd});
            wait_strobe(n);
            check("grant_latency", n, 1);
            serve(vt[i].wait_n, vt[i].rd, vt[i].chg, rc);
        end

        // Simultaneous I and D: D first, I strobe two cycles after DONE.
        @(posedge clk); #1;
        i0 = i_cnt; d0 = d_cnt;
        I_read = 1'b1; I_address = 16'h0100;
        D_read = 1'b1; D_address = 16'h0200;
        q.push_back('{1'b1, 1'b0, 16'h0200, 128'h0});
        q.push_back('{1'b0, 1'b0, 16'h0100, 128'h0});
        wait_strobe(n);
        check("both_first_latency", n, 1);
        serve(1, {8{16'hAAAA}}, 1'b0, m_d);
        wait_strobe(n);
        check("both_second_latency", n, 2);
        serve(0, {8{16'hBBBB}}, 1'b0, m_i);
        check("i_resp_offset", m_i - m_d, 3);
        check("i_resp_count", i_cnt - i0, 1);
        check("d_resp_count", d_cnt - d0, 1);

        // D requests continuously while I waits.
        I_address = 16'h0110;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            I_read = (guard && k == 2) ? 1'b1 : 1'b1;
            D_read = 1'b1;
            D_address = 16'h0D00 + 16'(k);
            if (guard && k == 2) q.push_back('{1'b0, 1'b0, 16'h0110, 128'h0});
            else                 q.push_back('{1'b1, 1'b0, 16'h0D00 + 16'(k), 128'h0});
            wait_strobe(n);
            check("starve_latency", n, 1);
            serve(1, {8{16'hC000 + 16'(k)}}, 1'b0, rc);
        end
        @(posedge clk); #1;
        D_read = 1'b0;
        if (!guard) begin
            q.push_back('{1'b0, 1'b0, 16'h0110, 128'h0});
            wait_strobe(n);
            check("late_i_latency", n, 1);
            serve(0, {8{16'hDDDD}}, 1'b0, rc);
        end
        repeat (2) @(posedge clk);
        #2;
        check("starve_idle_busy", busy, 1'b0);
        check("starve_scoreboard_drained", q.size(), 0);

        // Reset during SERVE_D abandons the write without a response.
        @(posedge clk); #1;
        D_write = 1'b1; D_address = 16'h6000; D_wdata = {16{8'h3C}};
        q.push_back('{1'b1, 1'b1, 16'h6000, {16{8'h3C}}});
        wait_strobe(n);
        check("rst_txn_latency", n, 1);
        if (q.size() > 0) begin
            e = q.pop_front();
            check("rst_txn_address", L2_address, e.addr);
            check("rst_txn_write", L2_write, e.wr);
        end
        d0 = d_cnt;
        @(posedge clk); #1;
        reset = 1'b1;
        D_write = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        I_read = 1'b1; I_address = 16'h7770;
        q.push_back('{1'b0, 1'b0, 16'h7770, 128'h0});
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_strobes", {L2_read, L2_write}, 2'b00);
        check("midrst_address", L2_address, 16'h0);
        wait_strobe(n);
        check("post_rst_latency", n, 1);
        serve(2, {8{16'hEEEE}}, 1'b0, rc);
        @(posedge clk); #2;
        check("midrst_no_d_resp", d_cnt - d0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
